// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : MEM-stage access sequencer between the pipeline and a 32-bit
//             data RAM. Byte/halfword/word accesses take one RAM beat;
//             doubleword accesses are split into two word beats separated by
//             an idle GAP cycle so the RAM sees a fresh rising Enable edge.
//             Load data is zero/sign-extended to 64 bits. All outputs are
//             registered (Moore FSM: IDLE, BEAT0, GAP, BEAT1, RESP).
//  Ports    : clk, rst_n (async, active-low)
//             req_valid/req_rw/req_mode/req_signed/req_addr/req_wdata
//                                            - pipeline request
//             busy                           - pipeline stall
//             rsp_valid/rsp_rdata/align_err  - completion pulse + result
//             ram_enable/ram_rw/ram_mode/ram_addr/ram_wdata/ram_rdata
//                                            - data RAM interface
//  Config   : define MEM_ALIGN_CHECK_EN to compile in misalignment detection;
//             without it align_err stays 0 and every request is executed.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_rw,
    input  logic [1:0]  req_mode,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        align_err,
    output logic        ram_enable,
    output logic        ram_rw,
    output logic [1:0]  ram_mode,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [1:0] c_mode_byte = 2'b00;
    localparam logic [1:0] c_mode_half = 2'b01;
    localparam logic [1:0] c_mode_word = 2'b10;
    localparam logic [1:0] c_mode_dw   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_GAP   = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;

    // Request fields latched at the accepting edge
    logic        r_rw,      w_rw_nxt;
    logic [1:0]  r_mode,    w_mode_nxt;
    logic        r_signed,  w_signed_nxt;
    logic [31:0] r_addr,    w_addr_nxt;
    logic [31:0] r_wdata_lo, w_wdata_lo_nxt;
    // Upper word of a doubleword load, captured at the end of BEAT0
    logic [31:0] r_hi,      w_hi_nxt;

    // Next values of the registered outputs
    logic [63:0] w_rsp_rdata_nxt;
    logic        w_align_err_nxt;
    logic        w_ram_rw_nxt;
    logic [1:0]  w_ram_mode_nxt;
    logic [31:0] w_ram_addr_nxt;
    logic [31:0] w_ram_wdata_nxt;

    logic        w_misalign;

`ifdef MEM_ALIGN_CHECK_EN
    logic [2:0]  w_span;
    logic [32:0] w_last_byte;
    always_comb begin
        w_span = 3'd0;
        case (req_mode)
            c_mode_byte: w_span = 3'd0;
            c_mode_half: w_span = 3'd1;
            c_mode_word: w_span = 3'd3;
            default:     w_span = 3'd7;
        endcase
        // 33-bit sum so an address near 2^32 cannot wrap back under the limit
        w_last_byte = {1'b0, req_addr} + {30'd0, w_span};
        w_misalign  = ((req_addr[2:0] & w_span) != 3'd0) || (w_last_byte > 33'd255);
    end
`else
    assign w_misalign = 1'b0;
`endif

    function automatic logic [63:0] f_load_ext(input logic [1:0]  mode,
                                               input logic        sgn,
                                               input logic [31:0] data);
        logic [63:0] v;
        case (mode)
            c_mode_byte: v = {{56{sgn & data[7]}},  data[7:0]};
            c_mode_half: v = {{48{sgn & data[15]}}, data[15:0]};
            default:     v = {{32{sgn & data[31]}}, data[31:0]};
        endcase
        return v;
    endfunction

    always_comb begin
        w_state_nxt     = r_state;
        w_rw_nxt        = r_rw;
        w_mode_nxt      = r_mode;
        w_signed_nxt    = r_signed;
        w_addr_nxt      = r_addr;
        w_wdata_lo_nxt  = r_wdata_lo;
        w_hi_nxt        = r_hi;
        w_rsp_rdata_nxt = rsp_rdata;
        w_align_err_nxt = align_err;
        w_ram_rw_nxt    = ram_rw;
        w_ram_mode_nxt  = ram_mode;
        w_ram_addr_nxt  = ram_addr;
        w_ram_wdata_nxt = ram_wdata;

        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (req_valid) begin
                    w_rw_nxt       = req_rw;
                    w_mode_nxt     = req_mode;
                    w_signed_nxt   = req_signed;
                    w_addr_nxt     = req_addr;
                    w_wdata_lo_nxt = req_wdata[31:0];
                    if (w_misalign) begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_rdata_nxt = 64'd0;
                        w_align_err_nxt = 1'b1;
                    end else begin
                        // RAM drive for BEAT0 comes straight from the request,
                        // since the latches only update on this same edge.
                        w_state_nxt     = ST_BEAT0;
                        w_ram_rw_nxt    = req_rw;
                        w_ram_addr_nxt  = req_addr;
                        w_ram_mode_nxt  = (req_mode == c_mode_dw) ? c_mode_word : req_mode;
                        w_ram_wdata_nxt = (req_mode == c_mode_dw) ? req_wdata[63:32]
                                                                  : req_wdata[31:0];
                    end
                end
            end
            ST_BEAT0: begin
                if (r_mode == c_mode_dw) begin
                    w_state_nxt = ST_GAP;
                    w_hi_nxt    = ram_rdata;
                end else begin
                    w_state_nxt     = ST_RESP;
                    w_align_err_nxt = 1'b0;
                    w_rsp_rdata_nxt = r_rw ? 64'd0 : f_load_ext(r_mode, r_signed, ram_rdata);
                end
            end
            ST_GAP: begin
                w_state_nxt     = ST_BEAT1;
                w_ram_addr_nxt  = r_addr + 32'd4;
                w_ram_wdata_nxt = r_wdata_lo;
            end
            ST_BEAT1: begin
                w_state_nxt     = ST_RESP;
                w_align_err_nxt = 1'b0;
                w_rsp_rdata_nxt = r_rw ? 64'd0 : {r_hi, ram_rdata};
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rw       <= 1'b0;
            r_mode     <= 2'b00;
            r_signed   <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata_lo <= 32'd0;
            r_hi       <= 32'd0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 64'd0;
            align_err  <= 1'b0;
            ram_enable <= 1'b0;
            ram_rw     <= 1'b0;
            ram_mode   <= 2'b00;
            ram_addr   <= 32'd0;
            ram_wdata  <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rw       <= w_rw_nxt;
            r_mode     <= w_mode_nxt;
            r_signed   <= w_signed_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata_lo <= w_wdata_lo_nxt;
            r_hi       <= w_hi_nxt;
            busy       <= (w_state_nxt == ST_BEAT0) || (w_state_nxt == ST_GAP) ||
                          (w_state_nxt == ST_BEAT1);
            rsp_valid  <= (w_state_nxt == ST_RESP);
            rsp_rdata  <= w_rsp_rdata_nxt;
            align_err  <= w_align_err_nxt;
            ram_enable <= (w_state_nxt == ST_BEAT0) || (w_state_nxt == ST_BEAT1);
            ram_rw     <= w_ram_rw_nxt;
            ram_mode   <= w_ram_mode_nxt;
            ram_addr   <= w_ram_addr_nxt;
            ram_wdata  <= w_ram_wdata_nxt;
        end
    end

endmodule
`default_nettype wire
